// File: rtl/lockstep_cmp_if.sv
// Signal bundle between a lockstep comparator and whatever drives it.
// master drives the compare strobe, clear, both channel buses and the mask.
interface lockstep_cmp_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      en;
  logic                      clr;
  logic [CHANNELS*WIDTH-1:0] a;
  logic [CHANNELS*WIDTH-1:0] b;
  logic [CHANNELS-1:0]       mask;
  logic                      ready;
  logic                      mismatch;
  logic                      err;
  logic [CH_W-1:0]           err_chan;
  logic [CNT_W-1:0]          err_cycle;
  logic [CNT_W-1:0]          mismatch_cnt;

  modport master (
    output en, clr, a, b, mask,
    input  ready, mismatch, err, err_chan, err_cycle, mismatch_cnt
  );

  modport slave (
    input  en, clr, a, b, mask,
    output ready, mismatch, err, err_chan, err_cycle, mismatch_cnt
  );
endinterface

// File: rtl/lockstep_cmp.sv
// Registered N-channel lockstep comparator: warm-up window, per-channel masking,
// sticky first-failure diagnostics and a saturating mismatch counter.
module lockstep_cmp #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int WARMUP   = 2,
  parameter int CNT_W    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  lockstep_cmp_if.slave cmp
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int WC_W = $clog2(WARMUP + 2);
  localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(WARMUP);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_WARM,
    S_LIVE,
    S_FAIL
  } state_t;

  state_t           state_reg, state_next;
  logic [WC_W-1:0]  warm_cnt_reg, warm_cnt_next;
  logic [CNT_W-1:0] stamp_reg, stamp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mismatch_reg, mismatch_next;
  logic [CH_W-1:0]  err_chan_reg, err_chan_next;
  logic [CNT_W-1:0] err_cycle_reg, err_cycle_next;

  logic [CHANNELS-1:0] hit;
  logic                any_hit;
  logic [CH_W-1:0]     first_chan;
  logic [WC_W-1:0]     warm_inc;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
      assign hit[gi] = cmp.en & ~cmp.mask[gi] &
                       (cmp.a[gi*WIDTH +: WIDTH] != cmp.b[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  assign any_hit  = |hit;
  assign warm_inc = warm_cnt_reg + WC_W'(1);

  // Walk downwards so the lowest failing index is the one that sticks.
  always_comb begin
    first_chan = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (hit[k]) first_chan = CH_W'(k);
    end
  end

  always_comb begin
    state_next     = state_reg;
    warm_cnt_next  = warm_cnt_reg;
    stamp_next     = stamp_reg;
    cnt_next       = cnt_reg;
    mismatch_next  = 1'b0;
    err_chan_next  = err_chan_reg;
    err_cycle_next = err_cycle_reg;

    if (cmp.clr) begin
      // Clear discards any same-cycle mismatch and restarts warm-up.
      state_next     = S_WARM;
      warm_cnt_next  = '0;
      stamp_next     = '0;
      cnt_next       = '0;
      err_chan_next  = '0;
      err_cycle_next = '0;
    end else begin
      case (state_reg)
        S_WARM: begin
          if (WARMUP == 0) begin
            state_next = S_LIVE;
          end else if (cmp.en) begin
            warm_cnt_next = warm_inc;
            if (warm_inc == WARM_LAST) state_next = S_LIVE;
          end
        end
        S_LIVE, S_FAIL: begin
          if (cmp.en) begin
            mismatch_next = any_hit;
            if (stamp_reg != CNT_MAX) stamp_next = stamp_reg + CNT_W'(1);
            if (any_hit && (cnt_reg != CNT_MAX)) cnt_next = cnt_reg + CNT_W'(1);
            if (any_hit && (state_reg == S_LIVE)) begin
              state_next     = S_FAIL;
              err_chan_next  = first_chan;
              err_cycle_next = stamp_reg;
            end
          end
        end
        default: state_next = S_WARM;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_WARM;
      warm_cnt_reg  <= '0;
      stamp_reg     <= '0;
      cnt_reg       <= '0;
      mismatch_reg  <= 1'b0;
      err_chan_reg  <= '0;
      err_cycle_reg <= '0;
    end else begin
      state_reg     <= state_next;
      warm_cnt_reg  <= warm_cnt_next;
      stamp_reg     <= stamp_next;
      cnt_reg       <= cnt_next;
      mismatch_reg  <= mismatch_next;
      err_chan_reg  <= err_chan_next;
      err_cycle_reg <= err_cycle_next;
    end
  end

  assign cmp.ready        = (state_reg != S_WARM);
  assign cmp.err          = (state_reg == S_FAIL);
  assign cmp.mismatch     = mismatch_reg;
  assign cmp.err_chan     = err_chan_reg;
  assign cmp.err_cycle    = err_cycle_reg;
  assign cmp.mismatch_cnt = cnt_reg;
endmodule

// File: tb/tb_lockstep_cmp.sv
// Scoreboard bench for lockstep_cmp: directed vectors push hand-computed expectations,
// per-DUT monitors pop and compare after each clock edge.
module tb_lockstep_cmp;
  typedef struct packed {
    logic       ready;
    logic       mm;
    logic       err;
    logic       chan;
    logic [7:0] cyc;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   tx0 = 0;
  int   tx1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, g0, e1, g1;

  always #5 clk = ~clk;

  lockstep_cmp_if #(.WIDTH(4), .CHANNELS(2), .CNT_W(8)) if0 ();
  lockstep_cmp_if #(.WIDTH(4), .CHANNELS(2), .CNT_W(3)) if1 ();

  lockstep_cmp #(.WIDTH(4), .CHANNELS(2), .WARMUP(2), .CNT_W(8)) dut0 (
    .clk_i(clk), .rst_i(rst0), .cmp(if0.slave));
  lockstep_cmp #(.WIDTH(4), .CHANNELS(2), .WARMUP(2), .CNT_W(3)) dut1 (
    .clk_i(clk), .rst_i(rst1), .cmp(if1.slave));

  task automatic step(input int sel, input logic rst, input logic en, input logic clr,
                      input logic [7:0] a, input logic [7:0] b, input logic [1:0] mask,
                      input logic ready, input logic mm, input logic err, input logic chan,
                      input logic [7:0] cyc, input logic [7:0] cnt);
    exp_t e;
    @(negedge clk);
    e = '{ready: ready, mm: mm, err: err, chan: chan, cyc: cyc, cnt: cnt};
    if (sel == 0) begin
      rst0 = rst; if0.en = en; if0.clr = clr; if0.a = a; if0.b = b; if0.mask = mask;
      q0.push_back(e);
    end else begin
      rst1 = rst; if1.en = en; if1.clr = clr; if1.a = a; if1.b = b; if1.mask = mask;
      q1.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      #1;
      g0 = '{ready: if0.ready, mm: if0.mismatch, err: if0.err, chan: if0.err_chan,
             cyc: if0.err_cycle, cnt: if0.mismatch_cnt};
      total_cnt++;
      tx0++;
      if (g0 === e0) begin
        pass_cnt++;
        $display("dut0 tx%0d ok rdy=%0b mm=%0b err=%0b ch=%0d cyc=%0d cnt=%0d",
                 tx0, g0.ready, g0.mm, g0.err, g0.chan, g0.cyc, g0.cnt);
      end else begin
        $display("FAIL dut0 tx%0d got rdy=%0b mm=%0b err=%0b ch=%0d cyc=%0d cnt=%0d want rdy=%0b mm=%0b err=%0b ch=%0d cyc=%0d cnt=%0d",
                 tx0, g0.ready, g0.mm, g0.err, g0.chan, g0.cyc, g0.cnt,
                 e0.ready, e0.mm, e0.err, e0.chan, e0.cyc, e0.cnt);
      end
    end
  end

  always @(posedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      #1;
      g1 = '{ready: if1.ready, mm: if1.mismatch, err: if1.err, chan: if1.err_chan,
             cyc: {5'b0, if1.err_cycle}, cnt: {5'b0, if1.mismatch_cnt}};
      total_cnt++;
      tx1++;
      if (g1 === e1) begin
        pass_cnt++;
        $display("dut1 tx%0d ok rdy=%0b mm=%0b err=%0b ch=%0d cyc=%0d cnt=%0d",
                 tx1, g1.ready, g1.mm, g1.err, g1.chan, g1.cyc, g1.cnt);
      end else begin
        $display("FAIL dut1 tx%0d got rdy=%0b mm=%0b err=%0b ch=%0d cyc=%0d cnt=%0d want rdy=%0b mm=%0b err=%0b ch=%0d cyc=%0d cnt=%0d",
                 tx1, g1.ready, g1.mm, g1.err, g1.chan, g1.cyc, g1.cnt,
                 e1.ready, e1.mm, e1.err, e1.chan, e1.cyc, e1.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired pass=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    if0.en = 0; if0.clr = 0; if0.a = '0; if0.b = '0; if0.mask = '0;
    if1.en = 0; if1.clr = 0; if1.a = '0; if1.b = '0; if1.mask = '0;

    // Reset state, then T1: matching data through warm-up into LIVE.
    step(0, 1,0,0, 8'h00,8'h00,2'b00, 0,0,0,0,0,0);
    step(0, 1,0,0, 8'h00,8'h00,2'b00, 0,0,0,0,0,0);
    for (int i = 1; i <= 10; i++)
      step(0, 0,1,0, 8'h3C,8'h3C,2'b00, (i >= 2),0,0,0,0,0);

    // T2: channel-1 mismatch at live stamp 3.
    step(0, 1,0,0, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);
    for (int i = 0; i < 3; i++)
      step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);
    step(0, 0,1,0, 8'h5C,8'h7C,2'b00, 1,1,1,1,3,1);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,1,1,3,1);

    // T3: both channels fail together, then channel 1 alone while in FAIL.
    step(0, 0,1,1, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);
    step(0, 0,1,0, 8'h12,8'h21,2'b00, 1,1,1,0,0,1);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,1,0,0,1);
    step(0, 0,1,0, 8'h5C,8'h7C,2'b00, 1,1,1,0,0,2);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,1,0,0,2);

    // T4: mismatches in WARM, with en low, and masked are ignored; unmasked one flags.
    step(0, 0,1,1, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(0, 0,0,0, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h5C,8'h7C,2'b00, 1,0,0,0,0,0);
    step(0, 0,1,0, 8'h5C,8'h7C,2'b10, 1,0,0,0,0,0);
    step(0, 0,0,0, 8'h5C,8'h7C,2'b00, 1,0,0,0,0,0);
    step(0, 0,1,0, 8'h12,8'h21,2'b11, 1,0,0,0,0,0);
    step(0, 0,1,0, 8'h5C,8'h7C,2'b01, 1,1,1,1,2,1);
    step(0, 0,0,0, 8'h5C,8'h7C,2'b00, 1,0,1,1,2,1);

    // T6: reset while in FAIL with a mismatch present, held for several edges.
    step(0, 1,1,0, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(0, 1,1,0, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(0, 1,1,0, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(0, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);
    step(0, 0,0,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);

    // T5 on CNT_W=3: stamp saturates at 7, then mismatch count saturates at 7.
    step(1, 1,0,0, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(1, 0,1,0, 8'h3C,8'h3C,2'b00, 0,0,0,0,0,0);
    step(1, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);
    for (int i = 0; i < 9; i++)
      step(1, 0,1,0, 8'h3C,8'h3C,2'b00, 1,0,0,0,0,0);
    for (int k = 1; k <= 9; k++)
      step(1, 0,1,0, 8'h5C,8'h7C,2'b00, 1,1,1,1,7, (k > 7) ? 8'd7 : 8'(k));
    step(1, 0,1,1, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(1, 0,1,0, 8'h5C,8'h7C,2'b00, 0,0,0,0,0,0);
    step(1, 0,1,0, 8'h5C,8'h7C,2'b00, 1,0,0,0,0,0);
    step(1, 0,1,0, 8'h5C,8'h7C,2'b00, 1,1,1,1,0,1);

    // Let the monitors drain, bounded.
    for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      total_cnt++;
      $display("FAIL drain q0=%0d q1=%0d left, want 0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
